// File: rtl/distri_fifo_pkg.sv
// Shared geometry and pointer type for the distributed-RAM FIFO.
// The pointer carries one extra wrap bit above the RAM address.
package distri_fifo_pkg;

    localparam int FIFO_DEPTH  = 32;
    localparam int FIFO_AWIDTH = 5;
    localparam int FIFO_PWIDTH = 6;

    typedef logic [FIFO_PWIDTH-1:0] ptr_t;

endpackage

// File: rtl/distri_ram.sv
// 32-entry distributed RAM: synchronous write port, asynchronous read port.
module distri_ram
    import distri_fifo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [FIFO_AWIDTH-1:0] write_addr_i,
    input  logic [XLEN-1:0]        data_i,
    input  logic [FIFO_AWIDTH-1:0] read_addr_i,
    output logic [XLEN-1:0]        data_o
);

    logic [XLEN-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[write_addr_i] <= data_i;
        end
    end

    assign data_o = mem[read_addr_i];

endmodule

// File: rtl/distri_fifo.sv
// First-word-fall-through FIFO wrapped around distri_ram; owns the pointers,
// occupancy and valid/ready flow control for both sides.
module distri_fifo
    import distri_fifo_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int AFULL_THRESH = 28
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            s_valid_i,
    output logic            s_ready_o,
    input  logic [XLEN-1:0] s_data_i,
    output logic            m_valid_o,
    input  logic            m_ready_i,
    output logic [XLEN-1:0] m_data_o,
    output logic [5:0]      count_o,
    output logic            afull_o
);

    localparam logic [5:0] AFULL_VAL = 6'(AFULL_THRESH);

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    logic empty;
    logic full;
    logic push_fire;
    logic pop_fire;

    // Equal addresses mean empty or full; the wrap bit tells them apart.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AWIDTH-1:0] == rd_ptr[FIFO_AWIDTH-1:0]) &&
                   (wr_ptr[FIFO_AWIDTH] != rd_ptr[FIFO_AWIDTH]);

    assign s_ready_o = !full;
    assign m_valid_o = !empty;
    assign push_fire = s_valid_i && s_ready_o;
    assign pop_fire  = m_valid_o && m_ready_i;

    assign count_o = wr_ptr - rd_ptr;
    assign afull_o = (count_o >= AFULL_VAL);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

    distri_ram #(
        .XLEN(XLEN)
    ) u_ram (
        .clk_i       (clk_i),
        .we_i        (push_fire),
        .write_addr_i(wr_ptr[FIFO_AWIDTH-1:0]),
        .data_i      (s_data_i),
        .read_addr_i (rd_ptr[FIFO_AWIDTH-1:0]),
        .data_o      (m_data_o)
    );

endmodule
